// File: rtl/barrel_shifter_pipe.sv
// Pipelined barrel shifter with a valid/ready handshake.
// There is one registered stage per shift-amount bit, and the LSB stage comes first.
// Stage k shifts by 2^k when bit k of the beat's amount is set.
// Each beat carries its own amount, its own mode and the MSB of the original operand.
// A full output that the consumer is not taking freezes the whole pipe, bubbles included.
// WIDTH must be a power of two and at least 2.
module barrel_shifter_pipe #(
   parameter int WIDTH = 8,
   localparam int SW = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [SW-1:0]    in_amt,
   input  logic [1:0]       in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
);

   // Per-stage registers: these hold the beat that the stage has already finished.
   logic             stg_valid [SW];
   logic [WIDTH-1:0] stg_data  [SW];
   logic [SW-1:0]    stg_amt   [SW];
   logic [1:0]       stg_mode  [SW];
   logic             stg_sign  [SW];

   // Stage inputs, and the value each stage will capture on the next edge.
   logic [WIDTH-1:0] src_data [SW];
   logic [SW-1:0]    src_amt  [SW];
   logic [1:0]       src_mode [SW];
   logic             src_sign [SW];
   logic [WIDTH-1:0] nxt_data [SW];

   logic             stall;

   // Shifts the operand by a fixed power of two in one of four modes.
   // The arithmetic-right fill uses the original operand MSB, not the current bit.
   // Earlier stages may already have moved that bit.
   function automatic logic [WIDTH-1:0] shift_step(
      input logic [WIDTH-1:0] d,
      input int               sh,
      input logic [1:0]       mode,
      input logic             sign
   );
      logic [WIDTH-1:0] fill;
      logic [WIDTH-1:0] res;
      fill = ~({WIDTH{1'b1}} >> sh) & {WIDTH{sign}};
      case (mode)
         2'b00:   res = (d << sh) | (d >> (WIDTH - sh));
         2'b01:   res = (d >> sh) | (d << (WIDTH - sh));
         2'b10:   res = d << sh;
         default: res = (d >> sh) | fill;
      endcase
      return res;
   endfunction

   // Result leaves the last stage; the reset gating keeps the outputs quiet while rst is held.
   assign out_valid = stg_valid[SW-1] && !rst;
   assign out_data  = rst ? '0 : stg_data[SW-1];
   assign stall     = out_valid && !out_ready;
   assign in_ready  = !stall;

   // Route each stage's input and apply its conditional 2^k shift.
   always_comb begin
      src_data[0] = in_data;
      src_amt[0]  = in_amt;
      src_mode[0] = in_mode;
      src_sign[0] = in_data[WIDTH-1];
      for (int k = 1; k < SW; k++) begin
         src_data[k] = stg_data[k-1];
         src_amt[k]  = stg_amt[k-1];
         src_mode[k] = stg_mode[k-1];
         src_sign[k] = stg_sign[k-1];
      end
      for (int k = 0; k < SW; k++) begin
         nxt_data[k] = src_amt[k][k] ? shift_step(src_data[k], 1 << k, src_mode[k], src_sign[k])
                                     : src_data[k];
      end
   end

   // Advance every stage in lockstep unless the output is stalled.
   // Reset empties the pipe and zeroes its contents.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < SW; k++) begin
            stg_valid[k] <= 1'b0;
            stg_data[k]  <= '0;
            stg_amt[k]   <= '0;
            stg_mode[k]  <= '0;
            stg_sign[k]  <= 1'b0;
         end
      end else if (!stall) begin
         stg_valid[0] <= in_valid && in_ready;
         for (int k = 1; k < SW; k++) begin
            stg_valid[k] <= stg_valid[k-1];
         end
         for (int k = 0; k < SW; k++) begin
            stg_data[k] <= nxt_data[k];
            stg_amt[k]  <= src_amt[k];
            stg_mode[k] <= src_mode[k];
            stg_sign[k] <= src_sign[k];
         end
      end
   end

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Self-checking bench for barrel_shifter_pipe at WIDTH=8.
// The bench keeps a cycle-level reference of its own: a three-slot delay line.
// The delay line freezes whenever the output is full and the consumer refuses it.
// Expected results come from plain arithmetic or from fixed values.
module tb_barrel_shifter_pipe;

   localparam int WIDTH = 8;
   localparam int SW    = 3;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic [SW-1:0]    in_amt;
   logic [1:0]       in_mode;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;

   int total = 0;
   int bad   = 0;

   logic             slotValid [SW];
   logic [WIDTH-1:0] slotData  [SW];

   barrel_shifter_pipe #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_amt    (in_amt),
      .in_mode   (in_mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
   );

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   // Reference result, computed with plain arithmetic on a doubled word.
   function automatic logic [WIDTH-1:0] refShift(input logic [WIDTH-1:0] d, input int amt,
                                                 input logic [1:0] mode);
      logic [2*WIDTH-1:0] dbl;
      logic [WIDTH-1:0]   r;
      dbl = {d, d};
      case (mode)
         2'b00: begin dbl = dbl << amt; r = dbl[2*WIDTH-1:WIDTH]; end
         2'b01: begin dbl = dbl >> amt; r = dbl[WIDTH-1:0]; end
         2'b10: r = d << amt;
         default: r = $signed(d) >>> amt;
      endcase
      return r;
   endfunction

   // Counts one comparison; a mismatch, including X/Z, prints a FAIL line.
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got=0x%0h expected=0x%0h at t=%0t", tag, got, exp, $time);
      end
   endtask

   // Runs one cycle: drive the inputs, check the outputs against the reference, then take the edge.
   // After the edge the reference is updated the same way the edge updates the DUT.
   task automatic applyStimulus(input logic r, input logic v, input logic [WIDTH-1:0] d,
                                input logic [SW-1:0] a, input logic [1:0] m, input logic ordy,
                                input logic [WIDTH-1:0] exp);
      logic stall;
      rst       = r;
      in_valid  = v;
      in_data   = d;
      in_amt    = a;
      in_mode   = m;
      out_ready = ordy;
      #1;
      stall = !r && slotValid[SW-1] && !ordy;
      if (r) begin
         checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
         checkOutput("rst_out_data", {24'd0, out_data}, 32'd0);
         checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
      end else begin
         checkOutput("out_valid", {31'd0, out_valid}, {31'd0, slotValid[SW-1]});
         checkOutput("in_ready", {31'd0, in_ready}, {31'd0, !stall});
         if (slotValid[SW-1]) checkOutput("out_data", {24'd0, out_data}, {24'd0, slotData[SW-1]});
      end
      @(posedge clk);
      if (r) begin
         for (int k = 0; k < SW; k++) begin
            slotValid[k] = 1'b0;
            slotData[k]  = '0;
         end
      end else if (!stall) begin
         for (int k = SW-1; k > 0; k--) begin
            slotValid[k] = slotValid[k-1];
            slotData[k]  = slotData[k-1];
         end
         slotValid[0] = v;
         slotData[0]  = exp;
      end
      #1;
   endtask

   // Offers one random beat; the expected value comes from the arithmetic reference.
   task automatic sendRandom(input logic v, input logic ordy);
      logic [WIDTH-1:0] d;
      logic [SW-1:0]    a;
      logic [1:0]       m;
      d = WIDTH'($urandom);
      a = SW'($urandom);
      m = 2'($urandom);
      applyStimulus(1'b0, v, d, a, m, ordy, refShift(d, int'(a), m));
   endtask

   // Runs idle cycles with the consumer ready so the pipe drains.
   task automatic flush(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b1, '0);
   endtask

   // Directed cases first, then backpressure, random traffic, reset mid-flight and bubbles.
   initial begin
      for (int k = 0; k < SW; k++) begin
         slotValid[k] = 1'b0;
         slotData[k]  = '0;
      end
      applyStimulus(1'b1, 1'b0, '0, '0, '0, 1'b1, '0);
      applyStimulus(1'b1, 1'b1, 8'h55, 3'd1, 2'b00, 1'b1, '0);

      applyStimulus(1'b0, 1'b1, 8'h12, 3'd3, 2'b00, 1'b1, 8'h90);
      applyStimulus(1'b0, 1'b1, 8'h12, 3'd3, 2'b01, 1'b1, 8'h42);
      applyStimulus(1'b0, 1'b1, 8'h12, 3'd7, 2'b10, 1'b1, 8'h00);
      applyStimulus(1'b0, 1'b1, 8'hFD, 3'd5, 2'b11, 1'b1, 8'hFF);
      applyStimulus(1'b0, 1'b1, 8'h1F, 3'd3, 2'b11, 1'b1, 8'h03);
      applyStimulus(1'b0, 1'b1, 8'h13, 3'd1, 2'b01, 1'b1, 8'h89);
      applyStimulus(1'b0, 1'b1, 8'h81, 3'd7, 2'b11, 1'b1, 8'hFF);
      applyStimulus(1'b0, 1'b1, 8'h81, 3'd1, 2'b00, 1'b1, 8'h03);
      for (int m = 0; m < 4; m++) applyStimulus(1'b0, 1'b1, 8'hA5, 3'd0, 2'(m), 1'b1, 8'hA5);
      flush(4);

      for (int i = 0; i < 3; i++) sendRandom(1'b1, 1'b1);
      for (int i = 0; i < 4; i++) sendRandom(1'b1, 1'b0);
      for (int i = 0; i < 2; i++) sendRandom(1'b1, 1'b1);
      flush(4);

      for (int i = 0; i < 300; i++) sendRandom(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0));
      flush(5);

      sendRandom(1'b1, 1'b1);
      sendRandom(1'b1, 1'b1);
      applyStimulus(1'b1, 1'b0, '0, '0, '0, 1'b1, '0);
      flush(3);
      sendRandom(1'b1, 1'b1);
      flush(4);

      sendRandom(1'b1, 1'b0);
      sendRandom(1'b1, 1'b1);
      applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b0, '0);
      applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b0, '0);
      applyStimulus(1'b1, 1'b1, 8'h3C, 3'd2, 2'b01, 1'b0, '0);
      flush(3);

      sendRandom(1'b1, 1'b1);
      sendRandom(1'b0, 1'b1);
      sendRandom(1'b1, 1'b1);
      sendRandom(1'b0, 1'b1);
      flush(5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/barrel_shifter_pipe.md
BARREL_SHIFTER_PIPE -- requirements
Module: barrel_shifter_pipe

Interface
REQ-001 Parameter WIDTH, default 8: data width in bits; SHALL be a power of two and at least 2.
REQ-002 Derived constant SW = log2(WIDTH): shift-amount width and pipeline depth; SHALL NOT be overridable.
REQ-003 Port clk, input, 1: single clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1: synchronous active-high reset.
REQ-005 Port in_valid, input, 1: input beat offered.
REQ-006 Port in_ready, output, 1: block accepts the input beat this cycle.
REQ-007 Port in_data, input, WIDTH: operand.
REQ-008 Port in_amt, input, SW: shift amount, 0..WIDTH-1.
REQ-009 Port in_mode, input, 2: 00 rotate left, 01 rotate right, 10 logical left, 11 arithmetic right.
REQ-010 Port out_valid, output, 1: result beat present.
REQ-011 Port out_ready, input, 1: consumer accepts the result beat.
REQ-012 Port out_data, output, WIDTH: shifted result.

Function
REQ-013 The datapath SHALL be SW registered stages; stage k SHALL apply a shift of 2^k when in_amt bit k is 1, LSB stage first.
REQ-014 Each stage SHALL register its data, a valid flag, the remaining amount bits, and the mode.
REQ-015 Latency SHALL be exactly SW cycles from the accepting edge to out_valid high, with no stall; WIDTH=8 gives 3 cycles.
REQ-016 Stall SHALL be defined as out_valid=1 and out_ready=0.
REQ-017 in_ready SHALL equal NOT stall, combinationally.
REQ-018 On stall, every stage register, including valid flags, SHALL hold its value, and out_data SHALL stay stable.
REQ-019 With no stall, every stage SHALL advance one position per cycle; stage 0 SHALL load in_valid AND in_ready.
REQ-020 Bubbles with valid=0 SHALL propagate and SHALL NOT be collapsed; throughput SHALL be one beat per cycle while out_ready=1.
REQ-021 A beat SHALL transfer at the output on any edge where out_valid=1 and out_ready=1.
REQ-022 Rotate modes SHALL feed the bits shifted out of one end back into the other end; no bit is lost.
REQ-023 Logical left SHALL fill vacated LSBs with 0.
REQ-024 Arithmetic right SHALL fill vacated MSBs with the original in_data MSB, carried unchanged through all stages.
REQ-025 in_amt=0 SHALL return in_data unchanged in every mode.
REQ-026 Beats SHALL exit in acceptance order, and each beat SHALL use only its own amount and mode.
REQ-027 in_data, in_amt and in_mode SHALL be don't-care when in_valid=0 or in_ready=0.

Reset
REQ-028 rst=1 at an edge SHALL clear all valid flags to 0, and SHALL clear all data, amount and mode registers to 0.
REQ-029 While rst=1: out_valid=0 and out_data=0; in_ready=1 follows from REQ-017, and beats offered are discarded.
REQ-030 A reset asserted while beats are in flight or stalled SHALL discard those beats; none SHALL appear after reset deasserts.
REQ-031 The first beat presented in the cycle after rst deasserts SHALL be accepted normally.

Verification (WIDTH=8)
REQ-032 Mode coverage, one beat per cycle with out_ready=1:
- 0x12 amt 3 mode 00 -> 0x90
- 0x12 amt 3 mode 01 -> 0x42
- 0x12 amt 7 mode 10 -> 0x00
- 0xFD amt 5 mode 11 -> 0xFF
- 0x1F amt 3 mode 11 -> 0x03
- 0x13 amt 1 mode 01 -> 0x89
- results appear 3 cycles after their inputs, in order.
REQ-033 Identity: 0xA5 with amt 0 in each of the four modes -> 0xA5 every time.
REQ-034 Backpressure: stream 5 beats, hold out_ready=0 for 4 cycles once out_valid is high -> in_ready=0, out_data stable, no beat lost or duplicated, all 5 correct after release.
REQ-035 Reset mid-flight: accept 2 beats, assert rst for 1 cycle -> out_valid stays 0 for the next 3 cycles with no input; a new beat afterwards emerges after 3 cycles.
REQ-036 Bubble pattern: in_valid toggles 1,0,1,0 -> out_valid follows the same pattern delayed by 3 cycles.
